// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer predictor: sizing defaults
// and the 2-bit direction counter encodings.
package btb_pkg;
    localparam int BTB_ENTRIES = 8;
    localparam int BTB_PC_STEP = 4;

    localparam logic [1:0] CTR_SNT  = 2'b00;
    localparam logic [1:0] CTR_WNT  = 2'b01;
    localparam logic [1:0] CTR_WT   = 2'b10;
    localparam logic [1:0] CTR_ST   = 2'b11;
    localparam logic [1:0] CTR_INIT = CTR_WT;
endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import btb_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);
    always_comb begin
        ctr_nxt = ctr;
        if (taken && ctr != CTR_ST)
            ctr_nxt = ctr + 2'd1;
        else if (!taken && ctr != CTR_SNT)
            ctr_nxt = ctr - 2'd1;
    end
endmodule

// File: rtl/btb_predictor.sv
// Fully-associative BTB with 2-bit direction counters: zero-latency lookup of the
// fetch PC, update from EX on resolved branches, plus branch/correct statistics.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int PC_STEP = BTB_PC_STEP,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [31:0]      pc_lookup,
    output logic [31:0]      pcpre,
    output logic             hit,
    output logic [IDX_W-1:0] hitpos,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_hit,
    input  logic [IDX_W-1:0] upd_hitpos,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pre_right,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_correct
);
    logic [ENTRIES-1:0]            valid;
    logic [ENTRIES-1:0][31:0]      tag;
    logic [ENTRIES-1:0][31:0]      target;
    logic [ENTRIES-1:0][1:0]       ctr;
    logic [ENTRIES-1:0][1:0]       ctr_nxt;
    logic [IDX_W-1:0]              rr;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter2 u_ctr (.ctr(ctr[g]), .taken(upd_taken), .ctr_nxt(ctr_nxt[g]));
    end

    // Lookup sees only registered state, so same-cycle updates are invisible here.
    always_comb begin
        hit    = 1'b0;
        hitpos = '0;
        pcpre  = pc_lookup + 32'(PC_STEP);
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == pc_lookup) begin
                hit    = 1'b1;
                hitpos = IDX_W'(i);
                if (ctr[i][1])
                    pcpre = target[i];
            end
        end
    end

    logic             hp_ok, rematch, free;
    logic [IDX_W-1:0] rm_pos, free_pos;

    // Descending scan leaves the lowest-index free slot in free_pos.
    always_comb begin
        hp_ok    = upd_hit && valid[upd_hitpos] && tag[upd_hitpos] == upd_pc;
        rematch  = 1'b0;
        rm_pos   = '0;
        free     = 1'b0;
        free_pos = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == upd_pc) begin
                rematch = 1'b1;
                rm_pos  = IDX_W'(i);
            end
            if (!valid[i]) begin
                free     = 1'b1;
                free_pos = IDX_W'(i);
            end
        end
    end

    logic [IDX_W-1:0] msel;
    assign msel = hp_ok ? upd_hitpos : rm_pos;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            valid         <= '0;
            tag           <= '0;
            target        <= '0;
            ctr           <= '0;
            rr            <= '0;
            stat_branches <= '0;
            stat_correct  <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            stat_correct  <= stat_correct + {31'd0, upd_pre_right};
            if (hp_ok || rematch) begin
                ctr[msel] <= ctr_nxt[msel];
                if (upd_taken)
                    target[msel] <= upd_target;
            end else if (upd_taken) begin
                if (free) begin
                    valid[free_pos]  <= 1'b1;
                    tag[free_pos]    <= upd_pc;
                    target[free_pos] <= upd_target;
                    ctr[free_pos]    <= CTR_INIT;
                end else begin
                    tag[rr]    <= upd_pc;
                    target[rr] <= upd_target;
                    ctr[rr]    <= CTR_INIT;
                    rr         <= (rr == IDX_W'(ENTRIES - 1)) ? '0 : rr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench: driver pushes expected lookup/stat values from a reference
// model each cycle, a negedge monitor pops and compares against the DUT.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pc_lookup = '0;
    logic [31:0] pcpre;
    logic        hit;
    logic [2:0]  hitpos;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_hit = 1'b0;
    logic [2:0]  upd_hitpos = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pre_right = 1'b0;
    logic [31:0] stat_branches, stat_correct;

    btb_predictor dut (
        .clk(clk), .RST(RST), .pc_lookup(pc_lookup), .pcpre(pcpre), .hit(hit),
        .hitpos(hitpos), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hit(upd_hit),
        .upd_hitpos(upd_hitpos), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pre_right(upd_pre_right), .stat_branches(stat_branches),
        .stat_correct(stat_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [2:0]  pos;
        logic [31:0] pcpre;
        logic [31:0] br;
        logic [31:0] cr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a list of slots with a direction strength 0..3.
    bit          m_valid[8];
    logic [31:0] m_tag[8];
    logic [31:0] m_tgt[8];
    int          m_ctr[8];
    int          m_rr;
    logic [31:0] m_br, m_cr;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_rr = 0; m_br = '0; m_cr = '0;
    endfunction

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        e.hit = 1'b0; e.pos = '0; e.pcpre = pc + 32'd4; e.br = m_br; e.cr = m_cr;
        for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_tag[i] == pc) begin
                e.hit = 1'b1;
                e.pos = 3'(i);
                if (m_ctr[i] >= 2) e.pcpre = m_tgt[i];
            end
        return e;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input bit uh, input int uhp,
                                         input bit tk, input logic [31:0] tgt, input bit pr);
        int slot = -1;
        m_br = m_br + 32'd1;
        if (pr) m_cr = m_cr + 32'd1;
        if (uh && m_valid[uhp] && m_tag[uhp] == pc) slot = uhp;
        else
            for (int i = 0; i < 8; i++)
                if (m_valid[i] && m_tag[i] == pc) slot = i;
        if (slot >= 0) begin
            m_ctr[slot] = tk ? ((m_ctr[slot] < 3) ? m_ctr[slot] + 1 : 3)
                             : ((m_ctr[slot] > 0) ? m_ctr[slot] - 1 : 0);
            if (tk) m_tgt[slot] = tgt;
        end else if (tk) begin
            for (int i = 7; i >= 0; i--)
                if (!m_valid[i]) slot = i;
            if (slot < 0) begin
                slot = m_rr;
                m_rr = (m_rr + 1) % 8;
            end
            m_valid[slot] = 1; m_tag[slot] = pc; m_tgt[slot] = tgt; m_ctr[slot] = 2;
        end
    endfunction

    task automatic step(input logic [31:0] look, input bit uv, input logic [31:0] pc,
                        input bit tk, input logic [31:0] tgt, input bit uh, input int uhp,
                        input bit pr);
        @(posedge clk); #1;
        pc_lookup = look; upd_valid = uv; upd_pc = pc; upd_taken = tk;
        upd_target = tgt; upd_hit = uh; upd_hitpos = 3'(uhp); upd_pre_right = pr;
        exp_q.push_back(model_lookup(look));
        if (uv) model_update(pc, uh, uhp, tk, tgt, pr);
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit uh, input int uhp, input bit pr);
        step(pc, 1, pc, tk, tgt, uh, uhp, pr);
    endtask

    // Reset lands mid-cycle with an update in flight; outputs must clear before any edge.
    task automatic rst_mid(input logic [31:0] look_pc);
        @(posedge clk); #1;
        pc_lookup = look_pc; upd_valid = 1'b1; upd_pc = look_pc; upd_taken = 1'b1;
        upd_target = 32'hDEAD_0000; upd_hit = 1'b0; upd_pre_right = 1'b1;
        #1 RST = 1'b1;
        model_reset();
        exp_q.push_back(model_lookup(look_pc));
        @(posedge clk); #1;
        RST = 1'b0; upd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (hit !== e.hit || hitpos !== e.pos || pcpre !== e.pcpre ||
                stat_branches !== e.br || stat_correct !== e.cr) begin
                n_bad++;
                $display("FAIL lookup pc=%h: got hit=%0d pos=%0d pcpre=%h br=%0d cr=%0d, want hit=%0d pos=%0d pcpre=%h br=%0d cr=%0d",
                         pc_lookup, hit, hitpos, pcpre, stat_branches, stat_correct,
                         e.hit, e.pos, e.pcpre, e.br, e.cr);
            end
        end
    end

    initial begin
        logic [31:0] pcs[16];
        model_reset();
        for (int i = 0; i < 16; i++) pcs[i] = 32'h1000 + 32'(i * 4);
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;

        // Reset state, allocation, counter walk with saturation at both ends.
        look(32'h40);
        upd(32'h40, 1, 32'h100, 0, 0, 1);
        look(32'h40);
        upd(32'h40, 0, 32'h0, 1, 0, 0);
        upd(32'h40, 0, 32'h0, 1, 0, 0);
        look(32'h40);
        upd(32'h40, 0, 32'h0, 1, 0, 1);
        look(32'h40);
        upd(32'h40, 1, 32'h180, 1, 0, 1);
        look(32'h40);
        upd(32'h40, 1, 32'h180, 1, 0, 1);
        upd(32'h40, 1, 32'h1C0, 1, 0, 1);
        upd(32'h40, 0, 32'h0, 1, 0, 0);
        look(32'h40);

        // Fill, round-robin replacement, stale hit info.
        rst_mid(32'h40);
        for (int i = 0; i < 8; i++) upd(32'(i * 4), 1, 32'h800 + 32'(i), 0, 0, 1);
        for (int i = 0; i < 8; i++) look(32'(i * 4));
        upd(32'h200, 1, 32'h900, 0, 0, 0);
        upd(32'h204, 1, 32'h904, 0, 0, 0);
        look(32'h0);
        upd(32'h0, 1, 32'h980, 1, 0, 1);
        look(32'h0); look(32'h200); look(32'h204); look(32'h8);
        upd(32'h300, 0, 32'h0, 0, 0, 0);
        look(32'h300);

        // Statistics, then async reset mid-sequence.
        rst_mid(32'h50);
        upd(32'h60, 1, 32'h600, 0, 0, 1);
        upd(32'h64, 0, 32'h0, 0, 0, 0);
        upd(32'h60, 1, 32'h640, 1, 0, 1);
        upd(32'h68, 1, 32'h680, 0, 0, 1);
        upd(32'h6C, 0, 32'h0, 0, 0, 0);
        look(32'h60);
        rst_mid(32'h60);
        look(32'h60);

        // Randomized traffic over a small PC pool.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] lp, up;
            bit uv, tk, uh;
            int uhp;
            exp_t le;
            lp = pcs[$urandom_range(0, 15)];
            up = pcs[$urandom_range(0, 15)];
            uv = ($urandom_range(0, 3) != 0);
            tk = $urandom_range(0, 1) == 1;
            le = model_lookup(up);
            if ($urandom_range(0, 1) == 1) begin
                uh = le.hit; uhp = int'(le.pos);
            end else begin
                uh = $urandom_range(0, 1) == 1; uhp = $urandom_range(0, 7);
            end
            if (n == 300) rst_mid(lp);
            else step(lp, uv, up, tk, $urandom, uh, uhp, $urandom_range(0, 1) == 1);
        end
        look(32'h0);
        @(posedge clk); #1 upd_valid = 1'b0;
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
